// File: rtl/spi_minion_array.sv
// Array of mode-0 SPI minion channels with one-entry rx/tx buffers, round-robin merge of received
// packets onto a single val/rdy stream, and sticky overflow / framing-error flags per channel.
module spi_minion_array #(
  parameter int unsigned NUM_MINIONS = 3,
  parameter int unsigned PACKET_BITS = 32,
  parameter int unsigned CHAN_BITS   = (NUM_MINIONS > 1) ? $clog2(NUM_MINIONS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_MINIONS-1:0] minion_cs_i,
  input  logic [NUM_MINIONS-1:0] minion_sclk_i,
  input  logic [NUM_MINIONS-1:0] minion_mosi_i,
  output logic [NUM_MINIONS-1:0] minion_miso_o,
  output logic [NUM_MINIONS-1:0] minion_parity_o,
  output logic [NUM_MINIONS-1:0] frame_err_o,
  output logic [PACKET_BITS-1:0] recv_msg_o,
  output logic [CHAN_BITS-1:0]   recv_chan_o,
  output logic                   recv_val_o,
  input  logic                   recv_rdy_i,
  input  logic [PACKET_BITS-1:0] send_msg_i,
  input  logic [CHAN_BITS-1:0]   send_chan_i,
  input  logic                   send_val_i,
  output logic                   send_rdy_o,
  input  logic                   clear_flags_i
);

  localparam int unsigned CntW = $clog2(PACKET_BITS + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(PACKET_BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(PACKET_BITS + 1);

  typedef enum logic {StIdle, StShift} st_e;

  // Two-stage synchronisers; the *_s3 copies hold the previous synchronised value for edge detect.
  logic [NUM_MINIONS-1:0] cs_s1_q, cs_s2_q, cs_s3_q;
  logic [NUM_MINIONS-1:0] sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic [NUM_MINIONS-1:0] mosi_s1_q, mosi_s2_q;
  logic [NUM_MINIONS-1:0] cs_fall, cs_rise, sclk_rise, sclk_fall;

  st_e                    st_q       [NUM_MINIONS];
  st_e                    st_d       [NUM_MINIONS];
  logic [CntW-1:0]        cnt_q      [NUM_MINIONS];
  logic [CntW-1:0]        cnt_d      [NUM_MINIONS];
  logic [PACKET_BITS-1:0] rx_shift_q [NUM_MINIONS];
  logic [PACKET_BITS-1:0] rx_shift_d [NUM_MINIONS];
  logic [PACKET_BITS-1:0] tx_shift_q [NUM_MINIONS];
  logic [PACKET_BITS-1:0] tx_shift_d [NUM_MINIONS];
  logic [PACKET_BITS-1:0] rx_buf_q   [NUM_MINIONS];
  logic [PACKET_BITS-1:0] rx_buf_d   [NUM_MINIONS];
  logic [PACKET_BITS-1:0] tx_buf_q   [NUM_MINIONS];
  logic [PACKET_BITS-1:0] tx_buf_d   [NUM_MINIONS];
  logic [NUM_MINIONS-1:0] rx_full_q, rx_full_d, tx_full_q, tx_full_d;
  logic [NUM_MINIONS-1:0] parity_q, parity_d, frame_q, frame_d;
  logic [NUM_MINIONS-1:0] deq, par_set, fe_set;

  logic [PACKET_BITS-1:0] recv_msg_q, recv_msg_d;
  logic [CHAN_BITS-1:0]   recv_chan_q, recv_chan_d, rr_q, rr_d;
  logic                   recv_val_q, recv_val_d;
  logic                   arb_go, found;

  assign cs_fall   = cs_s3_q & ~cs_s2_q;
  assign cs_rise   = ~cs_s3_q & cs_s2_q;
  assign sclk_rise = ~sclk_s3_q & sclk_s2_q;
  assign sclk_fall = sclk_s3_q & ~sclk_s2_q;

  always_comb begin
    recv_msg_d  = recv_msg_q;
    recv_chan_d = recv_chan_q;
    recv_val_d  = recv_val_q;
    rr_d        = rr_q;
    deq         = '0;
    found       = 1'b0;
    arb_go      = !recv_val_q || recv_rdy_i;

    // First full channel at or after the round-robin pointer, wrapping.
    if (arb_go) begin
      for (int k = 0; k < int'(NUM_MINIONS); k++) begin
        for (int c = 0; c < int'(NUM_MINIONS); c++) begin
          if (!found && ((int'(rr_q) + k) % int'(NUM_MINIONS) == c) && rx_full_q[c]) begin
            found       = 1'b1;
            deq[c]      = 1'b1;
            recv_msg_d  = rx_buf_q[c];
            recv_chan_d = CHAN_BITS'(c);
            rr_d        = CHAN_BITS'((c + 1) % int'(NUM_MINIONS));
          end
        end
      end
      recv_val_d = found;
    end
  end

  always_comb begin
    par_set = '0;
    fe_set  = '0;
    for (int c = 0; c < int'(NUM_MINIONS); c++) begin
      st_d[c]       = st_q[c];
      cnt_d[c]      = cnt_q[c];
      rx_shift_d[c] = rx_shift_q[c];
      tx_shift_d[c] = tx_shift_q[c];
      rx_buf_d[c]   = rx_buf_q[c];
      tx_buf_d[c]   = tx_buf_q[c];
      rx_full_d[c]  = rx_full_q[c] & ~deq[c];
      tx_full_d[c]  = tx_full_q[c];

      unique case (st_q[c])
        StIdle: begin
          if (cs_fall[c]) begin
            st_d[c]  = StShift;
            cnt_d[c] = '0;
            if (tx_full_q[c]) begin
              tx_shift_d[c] = tx_buf_q[c];
              tx_full_d[c]  = 1'b0;
            end else begin
              tx_shift_d[c] = '0;
            end
          end
        end
        StShift: begin
          if (cs_rise[c]) begin
            st_d[c] = StIdle;
            if (cnt_q[c] == CntFull) begin
              // A same-cycle dequeue frees the buffer, so this is not an overflow.
              if (rx_full_q[c] && !deq[c]) begin
                par_set[c] = 1'b1;
              end else begin
                rx_buf_d[c]  = rx_shift_q[c];
                rx_full_d[c] = 1'b1;
              end
            end else begin
              fe_set[c] = 1'b1;
            end
          end else begin
            if (sclk_rise[c]) begin
              rx_shift_d[c] = {rx_shift_q[c][PACKET_BITS-2:0], mosi_s2_q[c]};
              if (cnt_q[c] != CntSat) cnt_d[c] = cnt_q[c] + 1'b1;
            end
            if (sclk_fall[c]) tx_shift_d[c] = tx_shift_q[c] << 1;
          end
        end
        default: st_d[c] = StIdle;
      endcase

      // Checked against the registered tx_full so a write racing cs falling waits a transaction.
      if (send_val_i && (send_chan_i == CHAN_BITS'(c)) && !tx_full_q[c]) begin
        tx_buf_d[c]  = send_msg_i;
        tx_full_d[c] = 1'b1;
      end

      parity_d[c] = clear_flags_i ? 1'b0 : (parity_q[c] | par_set[c]);
      frame_d[c]  = clear_flags_i ? 1'b0 : (frame_q[c] | fe_set[c]);
    end
  end

  always_comb begin
    send_rdy_o = 1'b0;
    for (int c = 0; c < int'(NUM_MINIONS); c++) begin
      if (send_chan_i == CHAN_BITS'(c)) send_rdy_o = !tx_full_q[c];
      minion_miso_o[c] = (st_q[c] == StShift) && tx_shift_q[c][PACKET_BITS-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_s1_q     <= '0;
      cs_s2_q     <= '0;
      cs_s3_q     <= '0;
      sclk_s1_q   <= '0;
      sclk_s2_q   <= '0;
      sclk_s3_q   <= '0;
      mosi_s1_q   <= '0;
      mosi_s2_q   <= '0;
      rx_full_q   <= '0;
      tx_full_q   <= '0;
      parity_q    <= '0;
      frame_q     <= '0;
      recv_msg_q  <= '0;
      recv_chan_q <= '0;
      recv_val_q  <= 1'b0;
      rr_q        <= '0;
      for (int c = 0; c < int'(NUM_MINIONS); c++) begin
        st_q[c]       <= StIdle;
        cnt_q[c]      <= '0;
        rx_shift_q[c] <= '0;
        tx_shift_q[c] <= '0;
        rx_buf_q[c]   <= '0;
        tx_buf_q[c]   <= '0;
      end
    end else begin
      cs_s1_q     <= minion_cs_i;
      cs_s2_q     <= cs_s1_q;
      cs_s3_q     <= cs_s2_q;
      sclk_s1_q   <= minion_sclk_i;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      mosi_s1_q   <= minion_mosi_i;
      mosi_s2_q   <= mosi_s1_q;
      rx_full_q   <= rx_full_d;
      tx_full_q   <= tx_full_d;
      parity_q    <= parity_d;
      frame_q     <= frame_d;
      recv_msg_q  <= recv_msg_d;
      recv_chan_q <= recv_chan_d;
      recv_val_q  <= recv_val_d;
      rr_q        <= rr_d;
      for (int c = 0; c < int'(NUM_MINIONS); c++) begin
        st_q[c]       <= st_d[c];
        cnt_q[c]      <= cnt_d[c];
        rx_shift_q[c] <= rx_shift_d[c];
        tx_shift_q[c] <= tx_shift_d[c];
        rx_buf_q[c]   <= rx_buf_d[c];
        tx_buf_q[c]   <= tx_buf_d[c];
      end
    end
  end

  assign minion_parity_o = parity_q;
  assign frame_err_o     = frame_q;
  assign recv_msg_o      = recv_msg_q;
  assign recv_chan_o     = recv_chan_q;
  assign recv_val_o      = recv_val_q;

endmodule

// File: tb/tb_spi_minion_array.sv
// Bench for spi_minion_array: directed SPI transactions; expected packets queued at stimulus time
// and checked by an independent monitor on every recv handshake.
module tb_spi_minion_array;

  localparam int unsigned N = 3;
  localparam int unsigned P = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] cs = '1, sclk = '0, mosi = '0;
  logic [N-1:0] miso, parity, frame_err;
  logic [P-1:0] recv_msg, send_msg = '0;
  logic [1:0]   recv_chan, send_chan = '0;
  logic         recv_val, recv_rdy = 1'b1, send_val = 1'b0, send_rdy, clear_flags = 1'b0;

  logic [33:0]  exp_q[$];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  spi_minion_array #(.NUM_MINIONS(N), .PACKET_BITS(P)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .minion_cs_i    (cs),
    .minion_sclk_i  (sclk),
    .minion_mosi_i  (mosi),
    .minion_miso_o  (miso),
    .minion_parity_o(parity),
    .frame_err_o    (frame_err),
    .recv_msg_o     (recv_msg),
    .recv_chan_o    (recv_chan),
    .recv_val_o     (recv_val),
    .recv_rdy_i     (recv_rdy),
    .send_msg_i     (send_msg),
    .send_chan_i    (send_chan),
    .send_val_i     (send_val),
    .send_rdy_o     (send_rdy),
    .clear_flags_i  (clear_flags)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest expected packet.
  always @(negedge clk) begin
    if (rst_n && recv_val && recv_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_recv: got chan %0d msg %0h expected none", recv_chan, recv_msg);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("recv_chan", 64'(recv_chan), 64'(e[33:32]));
        check("recv_msg", 64'(recv_msg), 64'(e[31:0]));
      end
    end
  end

  task automatic push(input logic [1:0] ch, input logic [31:0] msg);
    exp_q.push_back({ch, msg});
  endtask

  task automatic spi_xfer(input int ch, input logic [31:0] data, input int nbits,
                          output logic [31:0] miso_word);
    @(posedge clk); #1;
    cs[ch] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    miso_word = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi[ch] = data[31-i];
      repeat (4) @(posedge clk);
      #1;
      miso_word = {miso_word[30:0], miso[ch]};
      sclk[ch] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      sclk[ch] = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    cs[ch] = 1'b1;
    mosi[ch] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of test expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w0, w1, w2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_recv_val", 64'(recv_val), 64'd0);
    check("rst_miso", 64'(miso), 64'd0);
    check("rst_parity", 64'(parity), 64'd0);
    check("rst_frame", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Plain receive on channel 0.
    push(2'd0, 32'hDEADBEEF);
    spi_xfer(0, 32'hDEADBEEF, 32, w0);
    wait_drain("drain_t1");
    check("t1_parity", 64'(parity), 64'd0);
    check("t1_frame", 64'(frame_err), 64'd0);

    // Response on channel 1 shifted out while a new packet is received.
    send_chan = 2'd1;
    send_msg  = 32'h12345678;
    #1;
    check("send_rdy_empty", 64'(send_rdy), 64'd1);
    send_val = 1'b1;
    @(posedge clk); #1;
    send_val = 1'b0;
    #1;
    check("send_rdy_full", 64'(send_rdy), 64'd0);
    send_chan = 2'd3;
    #1;
    check("send_rdy_badchan", 64'(send_rdy), 64'd0);
    send_chan = 2'd2;
    #1;
    check("send_rdy_ch2", 64'(send_rdy), 64'd1);
    send_chan = 2'd1;
    push(2'd1, 32'hA5A5A5A5);
    spi_xfer(1, 32'hA5A5A5A5, 32, w1);
    check("miso_word", 64'(w1), 64'h12345678);
    check("send_rdy_after", 64'(send_rdy), 64'd1);
    wait_drain("drain_t2");

    // Bring the pointer back to 0, then three simultaneous captures.
    push(2'd2, 32'h3C3C3C3C);
    spi_xfer(2, 32'h3C3C3C3C, 32, w2);
    wait_drain("drain_t3a");
    recv_rdy = 1'b0;
    push(2'd0, 32'h1);
    push(2'd1, 32'h2);
    push(2'd2, 32'h3);
    fork
      spi_xfer(0, 32'h1, 32, w0);
      spi_xfer(1, 32'h2, 32, w1);
      spi_xfer(2, 32'h3, 32, w2);
    join
    check("hold_val", 64'(recv_val), 64'd1);
    check("hold_chan", 64'(recv_chan), 64'd0);
    check("hold_msg", 64'(recv_msg), 64'h1);
    recv_rdy = 1'b1;
    wait_drain("drain_rr0");

    // Pointer to 1, then simultaneous captures again.
    push(2'd0, 32'h55);
    spi_xfer(0, 32'h55, 32, w0);
    wait_drain("drain_t3c");
    recv_rdy = 1'b0;
    push(2'd1, 32'h11);
    push(2'd2, 32'h22);
    push(2'd0, 32'h33);
    fork
      spi_xfer(0, 32'h33, 32, w0);
      spi_xfer(1, 32'h11, 32, w1);
      spi_xfer(2, 32'h22, 32, w2);
    join
    recv_rdy = 1'b1;
    wait_drain("drain_rr1");

    // Overflow on channel 2 while the output register is occupied.
    recv_rdy = 1'b0;
    push(2'd0, 32'h0000A0A0);
    spi_xfer(0, 32'h0000A0A0, 32, w0);
    push(2'd2, 32'h22220001);
    spi_xfer(2, 32'h22220001, 32, w2);
    spi_xfer(2, 32'h22220002, 32, w2);
    check("ovf_parity", 64'(parity), 64'b100);
    check("ovf_frame", 64'(frame_err), 64'd0);
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    check("clr_parity", 64'(parity), 64'd0);
    recv_rdy = 1'b1;
    wait_drain("drain_ovf");

    // Short transaction is a framing error; the channel recovers.
    spi_xfer(0, 32'hFFFFFFFF, 17, w0);
    check("fe_flag", 64'(frame_err), 64'b001);
    check("fe_recv_val", 64'(recv_val), 64'd0);
    push(2'd0, 32'h600DCAFE);
    spi_xfer(0, 32'h600DCAFE, 32, w0);
    wait_drain("drain_fe");
    check("fe_sticky", 64'(frame_err), 64'b001);

    // Reset in the middle of a channel 1 transaction.
    @(posedge clk); #1;
    cs[1] = 1'b0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 mosi[1] = i[0];
      repeat (4) @(posedge clk);
      #1 sclk[1] = 1'b1;
      repeat (4) @(posedge clk);
      #1 sclk[1] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_val", 64'(recv_val), 64'd0);
    check("mid_rst_miso", 64'(miso), 64'd0);
    check("mid_rst_parity", 64'(parity), 64'd0);
    check("mid_rst_frame", 64'(frame_err), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cs[1] = 1'b1;
    mosi[1] = 1'b0;
    repeat (8) @(posedge clk);
    push(2'd1, 32'h0BADF00D);
    spi_xfer(1, 32'h0BADF00D, 32, w1);
    wait_drain("drain_rst");
    check("post_rst_frame", 64'(frame_err), 64'd0);
    check("post_rst_parity", 64'(parity), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_minion_array.md
Name: spi_minion_array

Overview:
Parametrised successor to the single/triple SPI-minion front end used by the FFT SPI interconnect. Serves NUM_MINIONS independent mode-0 SPI minion channels. Each channel has a one-entry receive buffer and a one-entry transmit buffer. Received packets are merged into a single val/rdy stream by a round-robin arbiter, and responses are routed back per channel. Adds framing-error and overflow flags that the previous generation lacks.

Parameters:
NUM_MINIONS, 3, number of SPI minion channels (1..8)
PACKET_BITS, 32, bits per SPI transaction, MSB first
CHAN_BITS, $clog2(NUM_MINIONS) (min 1), width of channel index fields

Ports:
clk  input  1  system clock; must run at ≥4x the fastest minion_sclk
reset  input  1  asynchronous, active-low reset
minion_cs  input  NUM_MINIONS  per-channel chip select, active-low
minion_sclk  input  NUM_MINIONS  per-channel SPI clock
minion_mosi  input  NUM_MINIONS  per-channel master-out data
minion_miso  output  NUM_MINIONS  per-channel minion-out data
minion_parity  output  NUM_MINIONS  sticky overflow flag per channel
frame_err  output  NUM_MINIONS  sticky framing-error flag per channel
recv_msg  output  PACKET_BITS  received packet
recv_chan  output  CHAN_BITS  channel index of recv_msg
recv_val  output  1  recv_msg/recv_chan valid
recv_rdy  input  1  consumer accepts
send_msg  input  PACKET_BITS  response packet
send_chan  input  CHAN_BITS  target channel for send_msg
send_val  input  1  send_msg valid
send_rdy  output  1  target channel transmit buffer empty
clear_flags  input  1  clears all minion_parity and frame_err bits

Behaviour:
- Reset (reset=0, async): all shift regs, buffers, counters, flags = 0; RR pointer = 0; recv_val=0; minion_miso=0; minion_parity=0; frame_err=0.
- Reset asserted mid-transaction aborts it; no capture and no flag. After release, the channel waits for a fresh cs falling edge.
- Input sync: cs, sclk, mosi each pass through 2 flops. Edges are detected on the synchronised versions only.
- Per-channel FSM: IDLE -> SHIFT on cs falling; SHIFT -> IDLE on cs rising.
- cs falling: bit counter = 0. If tx_full, tx_shift = tx_buf and tx_full clears; otherwise tx_shift = 0.
- SHIFT, sclk rising: rx_shift = {rx_shift[PACKET_BITS-2:0], mosi}. Bit counter increments and saturates at PACKET_BITS+1.
- SHIFT, sclk falling: tx_shift shifts left by 1.
- minion_miso = tx_shift[MSB] while in SHIFT, else 0.
- cs rising, count==PACKET_BITS:
  - rx_full=0 → rx_buf = rx_shift, rx_full=1.
  - rx_full=1 → packet dropped, minion_parity[ch] set.
- cs rising, count!=PACKET_BITS: packet dropped, frame_err[ch] set.
- Same-cycle rule: if the arbiter dequeues rx_buf[ch] in the same cycle as cs rising on ch, the new packet is captured with no overflow.
- clear_flags has priority over a same-cycle flag set (flag reads 0 next cycle).
- Arbiter:
  - When recv_val=0, or on a recv_val&&recv_rdy handshake, selects the first full channel at or after the RR pointer (wrapping).
  - Registers recv_msg/recv_chan, clears that rx_full, sets recv_val=1, and sets pointer = granted+1 mod NUM_MINIONS.
  - recv_msg/recv_chan hold stable while recv_val&&!recv_rdy.
  - On a handshake with no channel full, recv_val drops to 0 next cycle.
- Capture latency: cs rising at pin → rx_full set 3 clk later (2 sync + edge detect) → recv_val 1 clk after that if idle.
- Send:
  - send_rdy = !tx_full[send_chan], combinational.
  - send_val&&send_rdy loads tx_buf[send_chan] and sets tx_full.
  - send_chan ≥ NUM_MINIONS: send_rdy=0.
  - Write in the same cycle as cs falling on that channel: cs falling sees the old empty state (shifts zeros); the write lands for the next transaction.

Test Plan:
- Single channel 0, 32-bit transfer of 0xDEADBEEF, recv_rdy=1 → one handshake with recv_msg=0xDEADBEEF, recv_chan=0; no flags set.
- send 0x12345678 to ch1, then SPI transaction on ch1 with mosi=0xA5A5A5A5 → master samples miso=0x12345678; recv_msg=0xA5A5A5A5, recv_chan=1; send_rdy for ch1 returns to 1 after cs falling.
- Channels 0, 1, 2 capture packets 0x1, 0x2, 0x3 while recv_rdy=0, then recv_rdy=1 → outputs in order ch0, ch1, ch2. Repeat with pointer at 1 → order ch1, ch2, ch0.
- Two complete packets on ch2 with recv_rdy=0 → first retained, minion_parity[2]=1; clear_flags pulse → minion_parity=0.
- Transaction on ch0 aborted after 17 sclk edges → frame_err[0]=1, recv_val stays 0; next full packet on ch0 is received normally.
- Assert reset mid-transaction on ch1 and release → all outputs 0; next full packet on ch1 is received correctly.
